// File: rtl/gray_ptr_sync_pkg.sv
// Shared Gray/binary conversion helpers and synchronizer depth limits for gray_ptr_sync.
package gray_ptr_sync_pkg;

   localparam int SYNC_STAGES_MIN = 2;
   localparam int SYNC_STAGES_MAX = 4;
   localparam int PTR_MAX_W       = 32;

   // Zero-extended inputs leave the upper result bits at zero, so callers can truncate.
   function automatic logic [PTR_MAX_W-1:0] gray2bin(input logic [PTR_MAX_W-1:0] gray);
      logic [PTR_MAX_W-1:0] bin;
      bin = gray;
      for (int i = 1; i < PTR_MAX_W; i++) begin
         bin = bin ^ (gray >> i);
      end
      return bin;
   endfunction

   function automatic logic [PTR_MAX_W-1:0] bin2gray(input logic [PTR_MAX_W-1:0] bin);
      return bin ^ (bin >> 1);
   endfunction

endpackage

// File: rtl/gray_ptr_sync_if.sv
// Read-pointer status bundle between the read domain source and the write-side consumer.
interface gray_ptr_sync_if #(parameter int ADDRSIZE = 4);

   logic [ADDRSIZE:0] rptr;
   logic [ADDRSIZE:0] wq_rptr;
   logic [ADDRSIZE:0] wq_rbin;
   logic              rptr_adv;
   logic [ADDRSIZE:0] adv_cnt;
   logic              err_clr;
   logic              ptr_err;

   modport master (
      output rptr,
      output err_clr,
      input  wq_rptr,
      input  wq_rbin,
      input  rptr_adv,
      input  adv_cnt,
      input  ptr_err
   );

   modport slave (
      input  rptr,
      input  err_clr,
      output wq_rptr,
      output wq_rbin,
      output rptr_adv,
      output adv_cnt,
      output ptr_err
   );

endinterface

// File: rtl/gray_ptr_sync_sync_chain.sv
// Generic N-flop vector synchronizer; reusable in either clock-crossing direction.
module sync_chain #(
   parameter int WIDTH  = 5,
   parameter int STAGES = 2
) (
   input  logic             wclk,
   input  logic             wrst_n,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] stage_r [STAGES];

   // Plain flop chain; nothing may sit between stages.
   always_ff @(posedge wclk or negedge wrst_n) begin
      if (!wrst_n) begin
         for (int i = 0; i < STAGES; i++) begin
            stage_r[i] <= '0;
         end
      end else begin
         stage_r[0] <= d;
         for (int i = 1; i < STAGES; i++) begin
            stage_r[i] <= stage_r[i-1];
         end
      end
   end

   assign q = stage_r[STAGES-1];

endmodule

// File: rtl/gray_ptr_sync.sv
// Read-to-write Gray pointer synchronizer with binary copy and advance reporting.
// Optional pointer-sanity checker enabled by defining GRAY_PTR_SYNC_CHECK_EN.
module gray_ptr_sync
   import gray_ptr_sync_pkg::*;
#(
   parameter int ADDRSIZE    = 4,
   parameter int SYNC_STAGES = 2
) (
   input  logic           wclk,
   input  logic           wrst_n,
   gray_ptr_sync_if.slave bus
);

   localparam int PW    = ADDRSIZE + 1;
   localparam int DEPTH = 2 ** ADDRSIZE;

   generate
      if (SYNC_STAGES < SYNC_STAGES_MIN || SYNC_STAGES > SYNC_STAGES_MAX) begin : g_bad_stages
         $error("gray_ptr_sync: SYNC_STAGES must be in 2..4");
      end
   endgenerate

   logic [PW-1:0] wq_rptr_s;
   logic [PW-1:0] rbin_next_s;
   logic [PW-1:0] diff_s;
   logic [PW-1:0] wq_rbin_r;
   logic [PW-1:0] adv_cnt_r;
   logic          rptr_adv_r;
   logic          ptr_err_s;

   sync_chain #(
      .WIDTH  (PW),
      .STAGES (SYNC_STAGES)
   ) u_sync_chain (
      .wclk   (wclk),
      .wrst_n (wrst_n),
      .d      (bus.rptr),
      .q      (wq_rptr_s)
   );

   // Modular distance between the freshly converted pointer and the held binary copy.
   always_comb begin
      rbin_next_s = PW'(gray2bin(PTR_MAX_W'(wq_rptr_s)));
      diff_s      = rbin_next_s - wq_rbin_r;
   end

   // Binary copy and one-cycle advance report.
   always_ff @(posedge wclk or negedge wrst_n) begin
      if (!wrst_n) begin
         wq_rbin_r  <= '0;
         adv_cnt_r  <= '0;
         rptr_adv_r <= 1'b0;
      end else begin
         wq_rbin_r  <= rbin_next_s;
         adv_cnt_r  <= diff_s;
         rptr_adv_r <= (diff_s != {PW{1'b0}});
      end
   end

`ifdef GRAY_PTR_SYNC_CHECK_EN
   logic viol_s;
   logic ptr_err_r;

   // A read pointer cannot legally advance more than DEPTH entries per wclk sample.
   always_comb begin
      viol_s = (diff_s > PW'(DEPTH));
   end

   // Sticky error; a new violation outranks a simultaneous clear.
   always_ff @(posedge wclk or negedge wrst_n) begin
      if (!wrst_n) begin
         ptr_err_r <= 1'b0;
      end else if (viol_s) begin
         ptr_err_r <= 1'b1;
      end else if (bus.err_clr) begin
         ptr_err_r <= 1'b0;
      end else begin
         ptr_err_r <= ptr_err_r;
      end
   end

   assign ptr_err_s = ptr_err_r;
`else
   logic unused_err_clr_s;
   assign unused_err_clr_s = bus.err_clr;
   assign ptr_err_s        = 1'b0;
`endif

   assign bus.wq_rptr  = wq_rptr_s;
   assign bus.wq_rbin  = wq_rbin_r;
   assign bus.rptr_adv = rptr_adv_r;
   assign bus.adv_cnt  = adv_cnt_r;
   assign bus.ptr_err  = ptr_err_s;

endmodule

// File: tb/tb_gray_ptr_sync.sv
// Scoreboard bench for gray_ptr_sync at SYNC_STAGES=2 and 4 side by side, ADDRSIZE=4.
module tb_gray_ptr_sync;

   localparam int AW = 4;

   typedef struct packed {
      logic [4:0] bin;
      logic [4:0] diff;
   } exp_t;

   logic wclk   = 1'b0;
   logic wrst_n = 1'b0;

   gray_ptr_sync_if #(.ADDRSIZE(AW)) bus2 ();
   gray_ptr_sync_if #(.ADDRSIZE(AW)) bus4 ();

   gray_ptr_sync #(.ADDRSIZE(AW), .SYNC_STAGES(2)) dut2 (.wclk(wclk), .wrst_n(wrst_n), .bus(bus2));
   gray_ptr_sync #(.ADDRSIZE(AW), .SYNC_STAGES(4)) dut4 (.wclk(wclk), .wrst_n(wrst_n), .bus(bus4));

   always #5 wclk = ~wclk;

   int         total = 0;
   int         bad   = 0;
   exp_t       q2[$];
   exp_t       q4[$];
   logic [4:0] last_b = 5'd0;
   logic       err2   = 1'b0;
   logic       err4   = 1'b0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   function automatic logic [4:0] to_gray(input logic [4:0] b);
      return b ^ (b >> 1);
   endfunction

   function automatic logic next_err(input logic cur, input logic [4:0] diff, input logic clr);
`ifdef GRAY_PTR_SYNC_CHECK_EN
      if (diff > 5'd16) return 1'b1;
      if (clr) return 1'b0;
      return cur;
`else
      return 1'b0;
`endif
   endfunction

   task automatic check_zero(input string tag);
      chk({tag, "_wq_rptr2"}, 32'(bus2.wq_rptr), 32'd0);
      chk({tag, "_wq_rbin2"}, 32'(bus2.wq_rbin), 32'd0);
      chk({tag, "_adv2"},     32'(bus2.rptr_adv), 32'd0);
      chk({tag, "_cnt2"},     32'(bus2.adv_cnt), 32'd0);
      chk({tag, "_err2"},     32'(bus2.ptr_err), 32'd0);
      chk({tag, "_wq_rptr4"}, 32'(bus4.wq_rptr), 32'd0);
      chk({tag, "_wq_rbin4"}, 32'(bus4.wq_rbin), 32'd0);
      chk({tag, "_adv4"},     32'(bus4.rptr_adv), 32'd0);
      chk({tag, "_cnt4"},     32'(bus4.adv_cnt), 32'd0);
      chk({tag, "_err4"},     32'(bus4.ptr_err), 32'd0);
   endtask

   task automatic check_out(input string tag, input exp_t e, input logic err_exp,
                            input logic [4:0] nxt_bin, input logic [4:0] wq_rptr,
                            input logic [4:0] wq_rbin, input logic adv,
                            input logic [4:0] cnt, input logic perr);
      chk($sformatf("%s_rbin_b%0d", tag, e.bin), 32'(wq_rbin), 32'(e.bin));
      chk($sformatf("%s_adv_b%0d", tag, e.bin), 32'(adv), 32'(e.diff != 5'd0));
      chk($sformatf("%s_cnt_b%0d", tag, e.bin), 32'(cnt), 32'(e.diff));
      chk($sformatf("%s_err_b%0d", tag, e.bin), 32'(perr), 32'(err_exp));
      chk($sformatf("%s_gray_b%0d", tag, nxt_bin), 32'(wq_rptr), 32'(to_gray(nxt_bin)));
   endtask

   // Compare outputs of the edge just past, then drive the next pointer and record its expectation.
   task automatic sample_and_drive(input logic [4:0] b, input logic clr);
      exp_t e;
      if (q2.size() >= 3) begin
         e    = q2.pop_front();
         err2 = next_err(err2, e.diff, bus2.err_clr);
         check_out("s2", e, err2, q2[0].bin, bus2.wq_rptr, bus2.wq_rbin,
                   bus2.rptr_adv, bus2.adv_cnt, bus2.ptr_err);
      end
      if (q4.size() >= 5) begin
         e    = q4.pop_front();
         err4 = next_err(err4, e.diff, bus4.err_clr);
         check_out("s4", e, err4, q4[0].bin, bus4.wq_rptr, bus4.wq_rbin,
                   bus4.rptr_adv, bus4.adv_cnt, bus4.ptr_err);
      end
      e.bin  = b;
      e.diff = b - last_b;
      last_b = b;
      q2.push_back(e);
      q4.push_back(e);
      bus2.rptr    = to_gray(b);
      bus4.rptr    = to_gray(b);
      bus2.err_clr = clr;
      bus4.err_clr = clr;
   endtask

   task automatic cycle(input logic [4:0] b, input logic clr);
      @(negedge wclk);
      sample_and_drive(b, clr);
   endtask

   task automatic hold(input logic [4:0] b, input int n);
      for (int i = 0; i < n; i++) cycle(b, 1'b0);
   endtask

   task automatic release_reset();
      @(negedge wclk);
      wrst_n = 1'b1;
      sample_and_drive(5'd0, 1'b0);
   endtask

   initial begin
      bus2.rptr    = 5'b10110;
      bus4.rptr    = 5'b10110;
      bus2.err_clr = 1'b0;
      bus4.err_clr = 1'b0;
      repeat (3) @(posedge wclk);
      #1;
      check_zero("rst");
      bus2.rptr = 5'd0;
      bus4.rptr = 5'd0;
      release_reset();

      hold(5'd0, 2);
      cycle(5'd1, 1'b0);
      hold(5'd1, 4);
      for (int b = 2; b <= 7; b++) cycle(5'(b), 1'b0);
      hold(5'd7, 6);

      // Asynchronous reset away from any clock edge.
      @(posedge wclk);
      #2;
      chk("pre_rst_rbin2", 32'(bus2.wq_rbin), 32'd7);
      chk("pre_rst_rbin4", 32'(bus4.wq_rbin), 32'd7);
      wrst_n = 1'b0;
      #1;
      check_zero("midrst");
      bus2.rptr = 5'd0;
      bus4.rptr = 5'd0;
      q2.delete();
      q4.delete();
      last_b = 5'd0;
      err2   = 1'b0;
      err4   = 1'b0;
      repeat (2) @(posedge wclk);
      release_reset();

      cycle(5'd8, 1'b0);
      cycle(5'd16, 1'b0);
      cycle(5'd24, 1'b0);
      cycle(5'd29, 1'b0);
      cycle(5'd30, 1'b0);
      cycle(5'd31, 1'b0);
      hold(5'd0, 3);
      cycle(5'd3, 1'b0);
      hold(5'd3, 2);
      cycle(5'd9, 1'b0);
      hold(5'd9, 2);
      cycle(5'd16, 1'b0);
      cycle(5'd0, 1'b0);
      hold(5'd0, 2);
      cycle(5'd20, 1'b0);
      hold(5'd20, 6);
      cycle(5'd20, 1'b1);
      hold(5'd20, 4);
      cycle(5'd24, 1'b0);
      hold(5'd0, 3);
      cycle(5'd20, 1'b0);
      cycle(5'd20, 1'b0);
      cycle(5'd20, 1'b1);
      hold(5'd20, 8);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
